// File: rtl/prj_pwm_pkg.sv
// rtl/prj_pwm_pkg.sv - Register map, bit indices, reset values and slew helper for the PWM ramp controller
package prj_pwm_pkg;

    typedef enum logic [1:0] {
        PWM_ADDR_CTRL     = 2'd0,
        PWM_ADDR_TARGET   = 2'd1,
        PWM_ADDR_PRESCALE = 2'd2,
        PWM_ADDR_STATUS   = 2'd3
    } pwm_addr_e;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_INVERT_BIT     = 1;
    localparam int CTRL_IRQ_EN_BIT     = 2;
    localparam int STATUS_BUSY_BIT     = 8;
    localparam int STATUS_IRQ_PEND_BIT = 9;

    localparam logic [7:0]  PWM_STEP_RST = 8'd1;
    localparam logic [15:0] PWM_DIV_RST  = 16'd0;

    // 9-bit arithmetic clamps at the target so the duty never wraps; step 0 acts as 1
    function automatic logic [7:0] pwm_slew(input logic [7:0] cur,
                                            input logic [7:0] tgt,
                                            input logic [7:0] step);
        logic [8:0] s;
        logic [8:0] up;
        s  = (step == 8'd0) ? 9'd1 : {1'b0, step};
        up = {1'b0, cur} + s;
        if (cur < tgt) begin
            return (up >= {1'b0, tgt}) ? tgt : up[7:0];
        end else if (cur > tgt) begin
            return ({1'b0, cur} <= ({1'b0, tgt} + s)) ? tgt : (cur - s[7:0]);
        end
        return cur;
    endfunction

endpackage

// File: rtl/prj_pwm_prescaler.sv
// rtl/prj_pwm_prescaler.sv - Clock prescaler producing one tick every div+1 clocks while enabled
module prj_pwm_prescaler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] r_pre_cnt;

    // >= rather than == so that lowering div mid-count ticks on the next clock
    assign tick = enable && (r_pre_cnt >= div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
        end else if (!enable || tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/prj_processor_pwm_ramp_ctrl.sv
// rtl/prj_processor_pwm_ramp_ctrl.sv - Avalon-MM PWM with per-period duty slew; PWM_RAMP_EN enables stepped ramp
module prj_processor_pwm_ramp_ctrl
    import prj_pwm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        irq
);

    logic [2:0]  r_ctrl;
    logic [7:0]  r_target;
    logic [15:0] r_div;
`ifdef PWM_RAMP_EN
    logic [7:0]  r_step;
`endif
    logic [7:0]  r_cnt;
    logic [7:0]  r_duty;
    logic        r_pwm;
    logic        r_irq_pend;

    pwm_addr_e   w_addr;
    logic        w_wr;
    logic        w_enable;
    logic        w_invert;
    logic        w_irq_en;
    logic        w_tick;
    logic        w_boundary;
    logic [7:0]  w_duty_next;
    logic        w_irq_set;
    logic        w_irq_clr;
    logic        w_busy;
    logic        w_unused_wdata;

    assign w_addr         = pwm_addr_e'(address);
    assign w_wr           = chipselect && !write_n;
    assign w_enable       = r_ctrl[CTRL_ENABLE_BIT];
    assign w_invert       = r_ctrl[CTRL_INVERT_BIT];
    assign w_irq_en       = r_ctrl[CTRL_IRQ_EN_BIT];
    assign w_busy         = (r_duty != r_target);
    assign w_unused_wdata = ^writedata;

    prj_pwm_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (w_enable),
        .div     (r_div),
        .tick    (w_tick)
    );

    assign w_boundary = w_tick && (r_cnt == 8'hFF);

`ifdef PWM_RAMP_EN
    assign w_duty_next = pwm_slew(r_duty, r_target, r_step);
`else
    assign w_duty_next = r_target;
`endif

    assign w_irq_set = w_boundary && w_busy && (w_duty_next == r_target);
    assign w_irq_clr = w_wr && (w_addr == PWM_ADDR_STATUS) && writedata[STATUS_IRQ_PEND_BIT];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl   <= '0;
            r_target <= '0;
            r_div    <= PWM_DIV_RST;
`ifdef PWM_RAMP_EN
            r_step   <= PWM_STEP_RST;
`endif
        end else if (w_wr) begin
            case (w_addr)
                PWM_ADDR_CTRL:   r_ctrl   <= writedata[2:0];
                PWM_ADDR_TARGET: r_target <= writedata[7:0];
                PWM_ADDR_PRESCALE: begin
                    r_div <= writedata[15:0];
`ifdef PWM_RAMP_EN
                    r_step <= writedata[23:16];
`endif
                end
                default: ;
            endcase
        end
    end

    // The boundary samples r_target before a same-edge TARGET write lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_duty     <= '0;
            r_pwm      <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            if (!w_enable) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_boundary) begin
                r_duty <= w_duty_next;
            end
            r_pwm <= w_enable ? ((r_cnt < r_duty) ^ w_invert) : w_invert;
            if (w_irq_set) begin
                r_irq_pend <= 1'b1;
            end else if (w_irq_clr) begin
                r_irq_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (w_addr)
            PWM_ADDR_CTRL:     readdata = {29'd0, r_ctrl};
            PWM_ADDR_TARGET:   readdata = {24'd0, r_target};
`ifdef PWM_RAMP_EN
            PWM_ADDR_PRESCALE: readdata = {8'd0, r_step, r_div};
`else
            PWM_ADDR_PRESCALE: readdata = {16'd0, r_div};
`endif
            PWM_ADDR_STATUS:   readdata = {22'd0, r_irq_pend, w_busy, r_duty};
            default:           readdata = '0;
        endcase
    end

    assign pwm_out = r_pwm;
    assign irq     = r_irq_pend & w_irq_en;

endmodule

// File: tb/tb_prj_processor_pwm_ramp_ctrl.sv
// tb/tb_prj_processor_pwm_ramp_ctrl.sv - Self-checking bench with a period-level behavioural model
module tb_prj_processor_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        pwm_out;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int m_duty   = 0;
    bit m_pend   = 1'b0;

    localparam logic [1:0] A_CTRL = 2'd0, A_TARGET = 2'd1, A_PRESCALE = 2'd2, A_STATUS = 2'd3;
`ifdef PWM_RAMP_EN
    localparam bit          RAMP = 1'b1;
    localparam logic [31:0] PRESCALE_RST = 32'h0001_0000;
`else
    localparam bit          RAMP = 1'b0;
    localparam logic [31:0] PRESCALE_RST = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    prj_processor_pwm_ramp_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .irq        (irq)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int model_next(int d, int t, int s);
        int se;
        if (!RAMP) return t;
        se = (s == 0) ? 1 : s;
        if (d < t) return (d + se < t) ? d + se : t;
        if (d > t) return (d - se > t) ? d - se : t;
        return d;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Counts high pwm samples over nclk clocks; optional write lands on the final edge
    task automatic run_period(input int nclk, input bit do_wr, input logic [1:0] wa,
                              input logic [31:0] wd, output int highs);
        highs = 0;
        for (int k = 1; k <= nclk; k++) begin
            if (do_wr && k == nclk) begin
                address = wa; writedata = wd; chipselect = 1'b1; write_n = 1'b0;
            end
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1;
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    task automatic set_duty(input int v);
        logic [31:0] rdata;
        int h;
        wr(A_CTRL, 32'd0);
        wr(A_PRESCALE, 32'h00FF_0000);
        wr(A_TARGET, v);
        wr(A_CTRL, 32'd1);
        run_period(256, 1'b0, 2'd0, 32'd0, h);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'h200);
        m_duty = v; m_pend = 1'b0;
        rd(A_STATUS, rdata);
        n_checks++;
        if (rdata[7:0] !== v[7:0] || rdata[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_duty: status got %h expected duty %0d pend 0", rdata, v);
        end
    endtask

    task automatic run_ramp(input int d0, input int t, input logic [7:0] step,
                            input logic [15:0] div, input bit inv, input bit ie, input int nper);
        logic [31:0] rdata;
        int highs, exp_h, nclk, nd;
        set_duty(d0);
        wr(A_PRESCALE, {8'd0, step, div});
        wr(A_TARGET, t);
        wr(A_CTRL, {29'd0, ie, inv, 1'b1});
        nclk = 256 * (int'(div) + 1);
        for (int p = 0; p < nper; p++) begin
            run_period(nclk, 1'b0, 2'd0, 32'd0, highs);
            exp_h = m_duty * (int'(div) + 1);
            if (inv) exp_h = nclk - exp_h;
            n_checks++;
            if (highs !== exp_h) begin
                n_fail++;
                $display("FAIL ramp_highs p%0d: got %0d expected %0d", p, highs, exp_h);
            end
            nd = model_next(m_duty, t, int'(step));
            if (nd != m_duty && nd == t) m_pend = 1'b1;
            m_duty = nd;
            rd(A_STATUS, rdata);
            n_checks++;
            if (rdata[7:0] !== m_duty[7:0]) begin
                n_fail++;
                $display("FAIL ramp_duty p%0d: got %0d expected %0d", p, rdata[7:0], m_duty);
            end
            n_checks++;
            if (rdata[8] !== (m_duty != t) || rdata[9] !== m_pend) begin
                n_fail++;
                $display("FAIL ramp_flags p%0d: busy %b pend %b expected %b %b",
                         p, rdata[8], rdata[9], (m_duty != t), m_pend);
            end
            n_checks++;
            if (irq !== (m_pend & ie)) begin
                n_fail++;
                $display("FAIL ramp_irq p%0d: got %b expected %b", p, irq, m_pend & ie);
            end
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] rdata;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'd0, 32'd0, PRESCALE_RST, 32'd0};
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pwm_out !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: pwm %b irq %b expected 0 0", pwm_out, irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rdata);
            n_checks++;
            if (rdata !== exp_rd[a]) begin
                n_fail++;
                $display("FAIL reset_read a%0d: got %h expected %h", a, rdata, exp_rd[a]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_waveform();
        run_ramp(0, 64, 8'd255, 16'd0, 1'b0, 1'b0, 3);
    endtask

    task automatic test_ramp_up();
        logic [31:0] rdata;
        run_ramp(0, 25, 8'd10, 16'd0, 1'b0, 1'b1, 4);
        wr(A_CTRL, 32'd4);
        n_checks++;
        if (irq !== m_pend) begin
            n_fail++;
            $display("FAIL irq_before_clear: got %b expected %b", irq, m_pend);
        end
        wr(A_STATUS, 32'h200);
        m_pend = 1'b0;
        rd(A_STATUS, rdata);
        n_checks++;
        if (irq !== 1'b0 || rdata[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: irq %b pend %b expected 0 0", irq, rdata[9]);
        end
    endtask

    task automatic test_ramp_down();
        run_ramp(25, 0, 8'd10, 16'd0, 1'b0, 1'b1, 4);
    endtask

    task automatic test_step0();
        run_ramp(5, 8, 8'd0, 16'd0, 1'b0, 1'b1, 4);
    endtask

    task automatic test_invert_disable();
        logic [31:0] rdata;
        int highs, bad, nd;
        set_duty(100);
        wr(A_CTRL, 32'd3);
        run_period(256, 1'b0, 2'd0, 32'd0, highs);
        n_checks++;
        if (highs !== 156) begin
            n_fail++;
            $display("FAIL invert_highs: got %0d expected 156", highs);
        end
        run_period(100, 1'b0, 2'd0, 32'd0, highs);
        wr(A_CTRL, 32'd2);
        wr(A_TARGET, 32'd30);
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (pwm_out !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL disabled_pwm: got %0d low samples expected 0", bad);
        end
        rd(A_STATUS, rdata);
        n_checks++;
        if (rdata[7:0] !== 8'd100) begin
            n_fail++;
            $display("FAIL disabled_frozen: got %0d expected 100", rdata[7:0]);
        end
        wr(A_CTRL, 32'd3);
        run_period(255, 1'b0, 2'd0, 32'd0, highs);
        rd(A_STATUS, rdata);
        n_checks++;
        if (highs !== 155 || rdata[7:0] !== 8'd100) begin
            n_fail++;
            $display("FAIL reenable_restart: highs %0d duty %0d expected 155 100", highs, rdata[7:0]);
        end
        run_period(1, 1'b0, 2'd0, 32'd0, highs);
        nd = model_next(100, 30, 255);
        m_duty = nd; m_pend = 1'b1;
        rd(A_STATUS, rdata);
        n_checks++;
        if (rdata[7:0] !== nd[7:0]) begin
            n_fail++;
            $display("FAIL reenable_boundary: got %0d expected %0d", rdata[7:0], nd);
        end
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_target_on_boundary();
        logic [31:0] rdata;
        int highs, d1, d2;
        set_duty(10);
        wr(A_PRESCALE, 32'h000A_0000);
        wr(A_TARGET, 32'd50);
        wr(A_CTRL, 32'd1);
        run_period(256, 1'b1, A_TARGET, 32'd0, highs);
        d1 = model_next(10, 50, 10);
        rd(A_STATUS, rdata);
        n_checks++;
        if (highs !== 10 || rdata[7:0] !== d1[7:0]) begin
            n_fail++;
            $display("FAIL target_boundary_old: highs %0d duty %0d expected 10 %0d", highs, rdata[7:0], d1);
        end
        run_period(256, 1'b0, 2'd0, 32'd0, highs);
        d2 = model_next(d1, 0, 10);
        rd(A_STATUS, rdata);
        n_checks++;
        if (highs !== d1 || rdata[7:0] !== d2[7:0]) begin
            n_fail++;
            $display("FAIL target_boundary_new: highs %0d duty %0d expected %0d %0d", highs, rdata[7:0], d1, d2);
        end
        m_duty = d2;
        wr(A_CTRL, 32'd0);
    endtask

    task automatic test_random();
        int d0, t;
        logic [7:0] s;
        logic [15:0] dv;
        bit inv, ie;
        for (int it = 0; it < 6; it++) begin
            d0  = $urandom_range(0, 255);
            t   = $urandom_range(0, 255);
            s   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 80));
            dv  = 16'($urandom_range(0, 2));
            inv = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            run_ramp(d0, t, s, dv, inv, ie, 3);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rdata;
        int highs;
        set_duty(0);
        wr(A_PRESCALE, 32'h00FF_0000);
        wr(A_TARGET, 32'd200);
        wr(A_CTRL, 32'd5);
        run_period(256, 1'b0, 2'd0, 32'd0, highs);
        run_period(50, 1'b0, 2'd0, 32'd0, highs);
        n_checks++;
        if (pwm_out !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: pwm %b irq %b expected 1 1", pwm_out, irq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (pwm_out !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pwm %b irq %b expected 0 0", pwm_out, irq);
        end
        rd(A_STATUS, rdata);
        n_checks++;
        if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_status: got %h expected 0", rdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_duty = 0; m_pend = 1'b0;
        rd(A_PRESCALE, rdata);
        n_checks++;
        if (rdata !== PRESCALE_RST) begin
            n_fail++;
            $display("FAIL async_reset_prescale: got %h expected %h", rdata, PRESCALE_RST);
        end
    endtask

    initial begin
        test_reset();
        test_waveform();
        test_ramp_up();
        test_ramp_down();
        test_step0();
        test_invert_disable();
        test_target_on_boundary();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
